// File: rtl/alu_exec_pkg.sv
// Shared types and control-word layout for the two-stage execute pipe.
package alu_exec_pkg;

   // control_in layout: [2:0] operation, [5:3] opselect, [6] imm_sel
   localparam int CTL_W       = 7;
   localparam int CTL_OP_LSB  = 0;
   localparam int CTL_OP_W    = 3;
   localparam int CTL_SEL_LSB = 3;
   localparam int CTL_SEL_W   = 3;
   localparam int CTL_IMM_BIT = 6;

   // Operation class, taken from the opselect field
   typedef enum logic [2:0] {
      OPS_SHIFT = 3'b000,
      OPS_ARITH = 3'b001,
      OPS_MUL   = 3'b010,
      OPS_STORE = 3'b100,
      OPS_LOAD  = 3'b101
   } opsel_e;

   // Operation field meaning when opselect is ARITH
   typedef enum logic [2:0] {
      ALU_ADD   = 3'b000,
      ALU_SUB   = 3'b001,
      ALU_AND   = 3'b010,
      ALU_OR    = 3'b011,
      ALU_XOR   = 3'b100,
      ALU_NOT   = 3'b101,
      ALU_PASSB = 3'b110,
      ALU_SLT   = 3'b111
   } alu_op_e;

   // Operation field meaning when opselect is SHIFT
   typedef enum logic [2:0] {
      SH_SLL = 3'b000,
      SH_SRL = 3'b001,
      SH_SRA = 3'b010,
      SH_ROL = 3'b011,
      SH_ROR = 3'b100
   } shift_op_e;

   // Stage-2 sequencing for the multi-cycle multiply
   typedef enum logic [1:0] {
      MUL_IDLE = 2'b00,
      MUL_BUSY = 2'b01,
      MUL_DONE = 2'b10
   } mul_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle over WIDTH
// cycles. done is asserted combinationally during the final iteration and
// product then carries the complete 2*WIDTH-bit result, so the caller can
// register it on the same edge that retires the last step.
module alu_mul_iter
   import alu_exec_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 CLOCK,
   input  logic                 RESET,
   input  logic                 start,
   input  logic [WIDTH-1:0]     op_a,
   input  logic [WIDTH-1:0]     op_b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CNT_W = $clog2(WIDTH);

   logic                busy_q,  busy_d;
   logic [CNT_W-1:0]    cnt_q,   cnt_d;
   logic [WIDTH-1:0]    mcand_q, mcand_d;
   logic [2*WIDTH-1:0]  prod_q,  prod_d;
   logic [WIDTH:0]      partial;
   logic [2*WIDTH-1:0]  prod_step;

   // Upper half accumulates the multiplicand when the current multiplier
   // bit (LSB of the product register) is set; the whole register then
   // shifts right by one, consuming that multiplier bit.
   assign partial   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
   assign prod_step = {partial, prod_q[WIDTH-1:1]};

   assign done    = busy_q && (cnt_q == '0);
   assign product = prod_step;

   // Next-state: load operands on start, then step once per cycle while busy
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and a latch is inferred.
      busy_d  = busy_q;
      cnt_d   = cnt_q;
      mcand_d = mcand_q;
      prod_d  = prod_q;
      if (busy_q) begin
         prod_d = prod_step;
         if (cnt_q == '0) begin
            busy_d = 1'b0;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end else if (start) begin
         busy_d  = 1'b1;
         cnt_d   = CNT_W'(WIDTH - 1);
         mcand_d = op_a;
         prod_d  = {{WIDTH{1'b0}}, op_b};
      end
   end

   // State registers with synchronous reset that aborts any multiply in flight
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         mcand_q <= '0;
         prod_q  <= '0;
      end else begin
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
      end
   end

endmodule

// File: rtl/alu_exec_pipe.sv
// Two-stage execute unit: stage 1 captures operands on a valid/ready
// handshake, stage 2 computes ALU/shift/load/store results in one cycle or
// runs the iterative multiplier while holding back new issues.
module alu_exec_pipe
   import alu_exec_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH),
   parameter int MUL_EN  = 1
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic              enable_ex,
   output logic              ready_out,
   input  logic [WIDTH-1:0]  src1,
   input  logic [WIDTH-1:0]  src2,
   input  logic [WIDTH-1:0]  imm,
   input  logic [WIDTH-1:0]  mem_data_read_in,
   input  logic [CTL_W-1:0]  control_in,
   output logic [WIDTH-1:0]  aluout,
   output logic              carry,
   output logic              out_valid,
   output logic [WIDTH-1:0]  mem_data_write_out,
   output logic              mem_data_wr_en
);

   // Stage 1
   logic              s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0]  s1_a_q,  s1_a_d;
   logic [WIDTH-1:0]  s1_b_q,  s1_b_d;
   logic [WIDTH-1:0]  s1_st_q, s1_st_d;
   logic [WIDTH-1:0]  s1_ld_q, s1_ld_d;
   logic [2:0]        s1_op_q, s1_op_d;
   logic [2:0]        s1_sel_q, s1_sel_d;

   // Stage 2
   mul_state_e        state_q, state_d;
   logic [WIDTH-1:0]  aluout_q, aluout_d;
   logic              carry_q, carry_d;
   logic              out_valid_q, out_valid_d;
   logic [WIDTH-1:0]  wr_data_q, wr_data_d;
   logic              wr_en_q, wr_en_d;

   logic              accept;
   logic              s2_free;
   logic              s2_go;
   logic              is_mul;
   logic              mul_start;
   logic              mul_done;
   logic [2*WIDTH-1:0] mul_product;

   // Datapath intermediates
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     sub_diff;
   logic [WIDTH:0]     sll_ext;
   logic [WIDTH:0]     srl_ext;
   logic [WIDTH:0]     sra_ext;
   logic [WIDTH-1:0]   rol_res;
   logic [WIDTH-1:0]   ror_res;
   logic               slt;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_cy;

   // Stage 2 is free to take the stage-1 op unless a multiply is iterating
   assign s2_free   = (state_q != MUL_BUSY);
   assign ready_out = !((state_q == MUL_BUSY) || (s1_valid_q && !s2_free));
   assign accept    = enable_ex && ready_out;
   assign s2_go     = s1_valid_q && s2_free;
   assign is_mul    = (s1_sel_q == OPS_MUL) && (MUL_EN != 0);

   // Stage-1 next state: capture on accept, hold while stage 2 is busy
   always_comb begin
      s1_valid_d = 1'b0;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_st_d    = s1_st_q;
      s1_ld_d    = s1_ld_q;
      s1_op_d    = s1_op_q;
      s1_sel_d   = s1_sel_q;
      if (accept) begin
         s1_valid_d = 1'b1;
         s1_a_d     = src1;
         s1_b_d     = control_in[CTL_IMM_BIT] ? imm : src2;
         s1_st_d    = src2;
         s1_ld_d    = mem_data_read_in;
         s1_op_d    = control_in[CTL_OP_LSB  +: CTL_OP_W];
         s1_sel_d   = control_in[CTL_SEL_LSB +: CTL_SEL_W];
      end else if (s1_valid_q && !s2_free) begin
         s1_valid_d = 1'b1;
      end
   end

   // Single-cycle arithmetic and shift candidates from the stage-1 operands
   assign shamt    = s1_b_q[SHAMT_W-1:0];
   assign add_sum  = {1'b0, s1_a_q} + {1'b0, s1_b_q};
   assign sub_diff = {1'b0, s1_a_q} + {1'b0, ~s1_b_q} + (WIDTH+1)'(1);
   assign sll_ext  = {1'b0, s1_a_q} << shamt;
   assign srl_ext  = {s1_a_q, 1'b0} >> shamt;
   assign sra_ext  = $signed({s1_a_q, 1'b0}) >>> shamt;
   assign rol_res  = (s1_a_q << shamt) | (s1_a_q >> (WIDTH - int'(shamt)));
   assign ror_res  = (s1_a_q >> shamt) | (s1_a_q << (WIDTH - int'(shamt)));
   assign slt      = $signed(s1_a_q) < $signed(s1_b_q);

   // Result/flag select for every single-cycle operation class
   always_comb begin
      alu_res = '0;
      alu_cy  = 1'b0;
      case (s1_sel_q)
         OPS_ARITH: begin
            case (s1_op_q)
               ALU_ADD:   {alu_cy, alu_res} = add_sum;
               ALU_SUB:   {alu_cy, alu_res} = sub_diff;
               ALU_AND:   alu_res = s1_a_q & s1_b_q;
               ALU_OR:    alu_res = s1_a_q | s1_b_q;
               ALU_XOR:   alu_res = s1_a_q ^ s1_b_q;
               ALU_NOT:   alu_res = ~s1_a_q;
               ALU_PASSB: alu_res = s1_b_q;
               ALU_SLT:   alu_res = {{(WIDTH-1){1'b0}}, slt};
               default:   alu_res = '0;
            endcase
         end
         OPS_SHIFT: begin
            case (s1_op_q)
               SH_SLL:  {alu_cy, alu_res} = sll_ext;
               SH_SRL:  {alu_res, alu_cy} = srl_ext;
               SH_SRA:  {alu_res, alu_cy} = sra_ext;
               SH_ROL:  alu_res = rol_res;
               SH_ROR:  alu_res = ror_res;
               default: alu_res = s1_a_q;
            endcase
         end
         OPS_LOAD:  alu_res = s1_ld_q;
         OPS_STORE: alu_res = add_sum[WIDTH-1:0];
         default:   alu_res = '0;
      endcase
   end

   // Stage-2 control: retire single-cycle ops, or sequence IDLE/BUSY/DONE for MUL
   always_comb begin
      state_d     = state_q;
      aluout_d    = aluout_q;
      carry_d     = carry_q;
      out_valid_d = 1'b0;
      wr_data_d   = wr_data_q;
      wr_en_d     = 1'b0;
      mul_start   = 1'b0;
      case (state_q)
         MUL_BUSY: begin
            if (mul_done) begin
               state_d     = MUL_DONE;
               aluout_d    = mul_product[WIDTH-1:0];
               carry_d     = |mul_product[2*WIDTH-1:WIDTH];
               out_valid_d = 1'b1;
            end
         end
         default: begin
            // DONE also takes the op held in stage 1 so it is not delayed further
            state_d = MUL_IDLE;
            if (s2_go) begin
               if (is_mul) begin
                  mul_start = 1'b1;
                  state_d   = MUL_BUSY;
               end else begin
                  aluout_d    = alu_res;
                  carry_d     = alu_cy;
                  out_valid_d = 1'b1;
                  if (s1_sel_q == OPS_STORE) begin
                     wr_en_d   = 1'b1;
                     wr_data_d = s1_st_q;
                  end
               end
            end
         end
      endcase
   end

   generate
      if (MUL_EN != 0) begin : g_mul
         alu_mul_iter #(
            .WIDTH (WIDTH)
         ) u_mul (
            .CLOCK   (CLOCK),
            .RESET   (RESET),
            .start   (mul_start),
            .op_a    (s1_a_q),
            .op_b    (s1_b_q),
            .done    (mul_done),
            .product (mul_product)
         );
      end else begin : g_no_mul
         assign mul_done    = 1'b0;
         assign mul_product = '0;
      end
   endgenerate

   // Control and output registers with synchronous reset
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         s1_valid_q  <= 1'b0;
         state_q     <= MUL_IDLE;
         aluout_q    <= '0;
         carry_q     <= 1'b0;
         out_valid_q <= 1'b0;
         wr_data_q   <= '0;
         wr_en_q     <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         state_q     <= state_d;
         aluout_q    <= aluout_d;
         carry_q     <= carry_d;
         out_valid_q <= out_valid_d;
         wr_data_q   <= wr_data_d;
         wr_en_q     <= wr_en_d;
      end
   end

   // Stage-1 payload registers
   always_ff @(posedge CLOCK) begin
      // NOTE: payload flops are left unreset; s1_valid_q gates every use, so their contents never matter while it is low.
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s1_st_q  <= s1_st_d;
      s1_ld_q  <= s1_ld_d;
      s1_op_q  <= s1_op_d;
      s1_sel_q <= s1_sel_d;
   end

   assign aluout             = aluout_q;
   assign carry              = carry_q;
   assign out_valid          = out_valid_q;
   assign mem_data_write_out = wr_data_q;
   assign mem_data_wr_en     = wr_en_q;

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Directed bench for alu_exec_pipe at WIDTH=32 plus a WIDTH=16 instance.
module tb_alu_exec_pipe;
   import alu_exec_pkg::*;

   logic        CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   logic        RESET, enable_ex, ready_out, carry, out_valid, mem_data_wr_en;
   logic [31:0] src1, src2, imm, mem_data_read_in, aluout, mem_data_write_out;
   logic [6:0]  control_in;

   logic        RESET16, en16, ready16, carry16, valid16, wen16;
   logic [15:0] a16, b16, imm16, ld16, alu16, wdat16;
   logic [6:0]  ctl16;

   int checks, errors;

   alu_exec_pipe #(.WIDTH(32)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .enable_ex(enable_ex), .ready_out(ready_out),
      .src1(src1), .src2(src2), .imm(imm), .mem_data_read_in(mem_data_read_in),
      .control_in(control_in), .aluout(aluout), .carry(carry), .out_valid(out_valid),
      .mem_data_write_out(mem_data_write_out), .mem_data_wr_en(mem_data_wr_en));

   alu_exec_pipe #(.WIDTH(16)) dut16 (
      .CLOCK(CLOCK), .RESET(RESET16), .enable_ex(en16), .ready_out(ready16),
      .src1(a16), .src2(b16), .imm(imm16), .mem_data_read_in(ld16),
      .control_in(ctl16), .aluout(alu16), .carry(carry16), .out_valid(valid16),
      .mem_data_write_out(wdat16), .mem_data_wr_en(wen16));

   function automatic logic [6:0] ctl(input logic [2:0] sel, input logic [2:0] op, input logic isel);
      return {isel, sel, op};
   endfunction

   // Issue one op on the 32-bit DUT and wait (bounded) for its out_valid pulse
   task automatic run_op(input logic [6:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [31:0] ld, output int lat,
                         output logic [31:0] res, output logic cy, output logic wen,
                         output logic [31:0] wdat);
      @(negedge CLOCK);
      control_in = c; src1 = a; src2 = b; imm = im; mem_data_read_in = ld; enable_ex = 1'b1;
      @(negedge CLOCK);
      enable_ex = 1'b0;
      lat = 1;
      while (!out_valid && lat < 60) begin
         @(negedge CLOCK);
         lat++;
      end
      res = aluout; cy = carry; wen = mem_data_wr_en; wdat = mem_data_write_out;
   endtask

   task automatic test_reset();
      RESET = 1'b1; RESET16 = 1'b1;
      repeat (3) @(negedge CLOCK);
      RESET = 1'b0; RESET16 = 1'b0;
      @(negedge CLOCK);
      checks++; if (aluout !== 32'h0) begin errors++; $display("FAIL rst_aluout got=%h want=%h", aluout, 32'h0); end
      checks++; if (carry !== 1'b0) begin errors++; $display("FAIL rst_carry got=%b want=0", carry); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
      checks++; if (mem_data_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got=%b want=0", mem_data_wr_en); end
      checks++; if (mem_data_write_out !== 32'h0) begin errors++; $display("FAIL rst_wr_data got=%h want=0", mem_data_write_out); end
      checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b want=1", ready_out); end
   endtask

   task automatic test_arith();
      int lat; logic [31:0] r, wd; logic c, we;
      run_op(ctl(OPS_ARITH, ALU_ADD, 1'b0), 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, lat, r, c, we, wd);
      checks++; if (lat !== 2) begin errors++; $display("FAIL add_latency got=%0d want=2", lat); end
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL add_res got=%h want=%h", r, 32'h0); end
      checks++; if (c !== 1'b1) begin errors++; $display("FAIL add_carry got=%b want=1", c); end
      run_op(ctl(OPS_ARITH, ALU_SUB, 1'b0), 32'd5, 32'd7, 32'h0, 32'h0, lat, r, c, we, wd);
      checks++; if (r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_res got=%h want=%h", r, 32'hFFFF_FFFE); end
      checks++; if (c !== 1'b0) begin errors++; $display("FAIL sub_carry got=%b want=0", c); end
      run_op(ctl(OPS_ARITH, ALU_SLT, 1'b0), 32'hFFFF_FFFD, 32'd2, 32'h0, 32'h0, lat, r, c, we, wd);
      checks++; if (r !== 32'h1) begin errors++; $display("FAIL slt_res got=%h want=%h", r, 32'h1); end
      run_op(ctl(OPS_ARITH, ALU_ADD, 1'b1), 32'd10, 32'd99, 32'd5, 32'h0, lat, r, c, we, wd);
      checks++; if (r !== 32'd15) begin errors++; $display("FAIL add_imm_res got=%h want=%h", r, 32'd15); end
      run_op(ctl(OPS_ARITH, ALU_XOR, 1'b0), 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h0, 32'h0, lat, r, c, we, wd);
      checks++; if (r !== 32'hFF00_EDCB) begin errors++; $display("FAIL xor_res got=%h want=%h", r, 32'hFF00_EDCB); end
   endtask

   task automatic test_shift();
      int lat; logic [31:0] r, wd; logic c, we;
      run_op(ctl(OPS_SHIFT, SH_SRA, 1'b1), 32'h8000_0000, 32'h0, 32'd4, 32'h0, lat, r, c, we, wd);
      checks++; if (r !== 32'hF800_0000) begin errors++; $display("FAIL sra_res got=%h want=%h", r, 32'hF800_0000); end
      checks++; if (c !== 1'b0) begin errors++; $display("FAIL sra_carry got=%b want=0", c); end
      run_op(ctl(OPS_SHIFT, SH_SLL, 1'b0), 32'h8000_0001, 32'd1, 32'h0, 32'h0, lat, r, c, we, wd);
      checks++; if (r !== 32'h2) begin errors++; $display("FAIL sll_res got=%h want=%h", r, 32'h2); end
      checks++; if (c !== 1'b1) begin errors++; $display("FAIL sll_carry got=%b want=1", c); end
      run_op(ctl(OPS_SHIFT, SH_ROR, 1'b0), 32'h0000_0001, 32'd4, 32'h0, 32'h0, lat, r, c, we, wd);
      checks++; if (r !== 32'h1000_0000) begin errors++; $display("FAIL ror_res got=%h want=%h", r, 32'h1000_0000); end
      checks++; if (c !== 1'b0) begin errors++; $display("FAIL ror_carry got=%b want=0", c); end
      run_op(ctl(OPS_SHIFT, SH_SRL, 1'b0), 32'h0000_000F, 32'd0, 32'h0, 32'h0, lat, r, c, we, wd);
      checks++; if (r !== 32'hF) begin errors++; $display("FAIL srl0_res got=%h want=%h", r, 32'hF); end
      checks++; if (c !== 1'b0) begin errors++; $display("FAIL srl0_carry got=%b want=0", c); end
   endtask

   task automatic test_load();
      int lat; logic [31:0] r, wd; logic c, we;
      run_op(ctl(OPS_LOAD, 3'b000, 1'b0), 32'h1, 32'h2, 32'h0, 32'hCAFE_F00D, lat, r, c, we, wd);
      checks++; if (r !== 32'hCAFE_F00D) begin errors++; $display("FAIL load_res got=%h want=%h", r, 32'hCAFE_F00D); end
      checks++; if (c !== 1'b0) begin errors++; $display("FAIL load_carry got=%b want=0", c); end
   endtask

   task automatic test_store();
      int lat; logic [31:0] r, wd; logic c, we;
      run_op(ctl(OPS_STORE, 3'b000, 1'b1), 32'h100, 32'hDEAD_BEEF, 32'h10, 32'h0, lat, r, c, we, wd);
      checks++; if (r !== 32'h110) begin errors++; $display("FAIL store_addr got=%h want=%h", r, 32'h110); end
      checks++; if (wd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_data got=%h want=%h", wd, 32'hDEAD_BEEF); end
      checks++; if (we !== 1'b1) begin errors++; $display("FAIL store_wr_en got=%b want=1", we); end
      @(negedge CLOCK);
      checks++; if (mem_data_wr_en !== 1'b0) begin errors++; $display("FAIL store_wr_en_pulse got=%b want=0", mem_data_wr_en); end
      checks++; if (aluout !== 32'h110) begin errors++; $display("FAIL store_hold got=%h want=%h", aluout, 32'h110); end
   endtask

   task automatic test_back_to_back();
      @(negedge CLOCK);
      control_in = ctl(OPS_ARITH, ALU_ADD, 1'b0); src1 = 32'd1; src2 = 32'd2; enable_ex = 1'b1;
      @(negedge CLOCK);
      src1 = 32'd3; src2 = 32'd4;
      @(negedge CLOCK);
      enable_ex = 1'b0;
      checks++; if (out_valid !== 1'b1 || aluout !== 32'd3) begin errors++; $display("FAIL b2b_first got=%b/%h want=1/%h", out_valid, aluout, 32'd3); end
      @(negedge CLOCK);
      checks++; if (out_valid !== 1'b1 || aluout !== 32'd7) begin errors++; $display("FAIL b2b_second got=%b/%h want=1/%h", out_valid, aluout, 32'd7); end
      @(negedge CLOCK);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse got=%b want=0", out_valid); end
      checks++; if (aluout !== 32'd7) begin errors++; $display("FAIL b2b_hold got=%h want=%h", aluout, 32'd7); end
   endtask

   task automatic test_mul();
      int low_cnt = 0, early = 0, pulses = 0;
      logic [31:0] add_res = '0;
      @(negedge CLOCK);
      control_in = ctl(OPS_MUL, 3'b000, 1'b0); src1 = 32'h1234; src2 = 32'h10; enable_ex = 1'b1;
      for (int k = 1; k <= 33; k++) begin
         @(negedge CLOCK);
         if (!ready_out) low_cnt++;
         if (out_valid) early++;
         if (k == 1) begin
            control_in = ctl(OPS_ARITH, ALU_ADD, 1'b0); src1 = 32'd1; src2 = 32'd1;
         end else begin
            enable_ex = 1'b0;
         end
      end
      @(negedge CLOCK);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mul_valid_at_34 got=%b want=1", out_valid); end
      checks++; if (aluout !== 32'h12340) begin errors++; $display("FAIL mul_res got=%h want=%h", aluout, 32'h12340); end
      checks++; if (carry !== 1'b0) begin errors++; $display("FAIL mul_carry got=%b want=0", carry); end
      checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL mul_done_ready got=%b want=1", ready_out); end
      checks++; if (low_cnt !== 32) begin errors++; $display("FAIL mul_ready_low got=%0d want=32", low_cnt); end
      checks++; if (early !== 0) begin errors++; $display("FAIL mul_early_valid got=%0d want=0", early); end
      for (int k = 0; k < 6; k++) begin
         @(negedge CLOCK);
         if (out_valid) begin
            pulses++;
            if (pulses == 1) add_res = aluout;
         end
      end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL mul_follow_count got=%0d want=1", pulses); end
      checks++; if (add_res !== 32'd2) begin errors++; $display("FAIL mul_follow_res got=%h want=%h", add_res, 32'd2); end
   endtask

   task automatic test_reset_mid_mul();
      int lat, pulses = 0; logic [31:0] r, wd; logic c, we;
      @(negedge CLOCK);
      control_in = ctl(OPS_MUL, 3'b000, 1'b0); src1 = 32'd5; src2 = 32'd6; enable_ex = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         @(negedge CLOCK);
         if (k == 1) begin
            control_in = ctl(OPS_ARITH, ALU_ADD, 1'b0); src1 = 32'd9; src2 = 32'd9;
         end else begin
            enable_ex = 1'b0;
         end
         if (k == 11) RESET = 1'b1;
      end
      @(negedge CLOCK);
      RESET = 1'b0;
      checks++; if (aluout !== 32'h0) begin errors++; $display("FAIL rmul_aluout got=%h want=0", aluout); end
      checks++; if (carry !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rmul_flags got=%b/%b want=0/0", carry, out_valid); end
      checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL rmul_ready got=%b want=1", ready_out); end
      for (int k = 0; k < 40; k++) begin
         @(negedge CLOCK);
         if (out_valid) pulses++;
      end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL rmul_stray_valid got=%0d want=0", pulses); end
      run_op(ctl(OPS_ARITH, ALU_ADD, 1'b0), 32'd20, 32'd22, 32'h0, 32'h0, lat, r, c, we, wd);
      checks++; if (lat !== 2) begin errors++; $display("FAIL rmul_add_latency got=%0d want=2", lat); end
      checks++; if (r !== 32'd42) begin errors++; $display("FAIL rmul_add_res got=%h want=%h", r, 32'd42); end
   endtask

   task automatic test_w16();
      int lat = 0, low = 0;
      @(negedge CLOCK);
      ctl16 = ctl(OPS_MUL, 3'b000, 1'b0); a16 = 16'h0100; b16 = 16'h0100; imm16 = '0; ld16 = '0; en16 = 1'b1;
      while (lat < 60) begin
         @(negedge CLOCK);
         lat++;
         en16 = 1'b0;
         if (!ready16) low++;
         if (valid16) break;
      end
      checks++; if (lat !== 18) begin errors++; $display("FAIL w16_mul_latency got=%0d want=18", lat); end
      checks++; if (alu16 !== 16'h0) begin errors++; $display("FAIL w16_mul_res got=%h want=%h", alu16, 16'h0); end
      checks++; if (carry16 !== 1'b1) begin errors++; $display("FAIL w16_mul_carry got=%b want=1", carry16); end
      checks++; if (low !== 16) begin errors++; $display("FAIL w16_ready_low got=%0d want=16", low); end
      @(negedge CLOCK);
      ctl16 = ctl(OPS_ARITH, ALU_ADD, 1'b0); a16 = 16'hFFFF; b16 = 16'h0001; en16 = 1'b1;
      @(negedge CLOCK);
      en16 = 1'b0;
      @(negedge CLOCK);
      checks++; if (valid16 !== 1'b1 || alu16 !== 16'h0) begin errors++; $display("FAIL w16_add got=%b/%h want=1/%h", valid16, alu16, 16'h0); end
      checks++; if (carry16 !== 1'b1) begin errors++; $display("FAIL w16_add_carry got=%b want=1", carry16); end
   endtask

   initial begin
      checks = 0; errors = 0;
      enable_ex = 1'b0; src1 = '0; src2 = '0; imm = '0; mem_data_read_in = '0; control_in = '0;
      en16 = 1'b0; a16 = '0; b16 = '0; imm16 = '0; ld16 = '0; ctl16 = '0;
      test_reset();
      test_arith();
      test_shift();
      test_load();
      test_store();
      test_back_to_back();
      test_mul();
      test_reset_mid_mul();
      test_w16();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
